tt_input_debounce: RTL and testbench

// - Front-end conditioner between the raw ui_in pads and the latch/flip-flop experiment stage.
// - Synchronises each input bit, rejects glitches and switch bounce, and emits a clean level per bit.
// - Also emits one-cycle rise/fall pulses so the downstream latches see exactly one WE/A/B/set edge per press.

---
 rtl/tt_io_pkg.sv | 10 +
 rtl/tt_input_debounce_if.sv | 11 +
 rtl/tt_debounce_bit.sv | 38 +++
 rtl/tt_input_debounce.sv | 38 +++
 tb/tb_tt_input_debounce.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/tt_io_pkg.sv
// tt_io_pkg: shared widths and default timing constants for the input conditioner.
package tt_io_pkg;
  localparam int TT_IO_WIDTH = 8;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_PRESCALE = 1;
  localparam int DEF_STABLE_COUNT = 4;
  function automatic int cnt_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/tt_input_debounce_if.sv
// tt_input_debounce_if: raw inputs in, conditioned levels and edge pulses out.
interface tt_input_debounce_if import tt_io_pkg::*; #(parameter int WIDTH = TT_IO_WIDTH) ();
  logic ena;
  logic [WIDTH-1:0] ui_in;
  logic [WIDTH-1:0] clean;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic changed;
  modport master (output ena, ui_in, input clean, rise, fall, changed);
  modport slave (input ena, ui_in, output clean, rise, fall, changed);
endinterface

// File: rtl/tt_debounce_bit.sv
// tt_debounce_bit: synchroniser, stability counter and edge pulses for one input bit.
module tt_debounce_bit #(
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_COUNT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic strobe,
  input  logic d,
  output logic clean,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(STABLE_COUNT + 1);
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] c;
  logic s;
  logic accept;
  assign s = sync[SYNC_STAGES-1];
  // acceptance is checked before incrementing, so c never passes STABLE_COUNT-1
  assign accept = ena && strobe && (s != clean) && (c == CW'(STABLE_COUNT - 1));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      c     <= '0;
      clean <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], d};
      rise  <= accept && s;
      fall  <= accept && !s;
      clean <= accept ? s : clean;
      c     <= (!ena || s == clean || accept) ? '0 : strobe ? c + 1'b1 : c;
    end
  end
endmodule

// File: rtl/tt_input_debounce.sv
// tt_input_debounce: per-bit debouncers sharing one sample prescaler and an enable gate.
module tt_input_debounce import tt_io_pkg::*; #(
  parameter int WIDTH = TT_IO_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int PRESCALE = DEF_PRESCALE,
  parameter int STABLE_COUNT = DEF_STABLE_COUNT
) (
  input logic clk,
  input logic rst_n,
  tt_input_debounce_if.slave io
);
  localparam int PW = cnt_width(PRESCALE);
  logic [PW-1:0] pcnt;
  logic strobe;
  logic [WIDTH-1:0] clean_v, rise_v, fall_v;
  // prescaler parks at 0 while disabled so the first enabled cycle strobes
  assign strobe = io.ena && pcnt == '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pcnt <= '0;
    else pcnt <= (!io.ena || pcnt == PW'(PRESCALE - 1)) ? '0 : pcnt + 1'b1;
  end
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    tt_debounce_bit #(.SYNC_STAGES(SYNC_STAGES), .STABLE_COUNT(STABLE_COUNT)) u_bit (
      .clk(clk),
      .rst_n(rst_n),
      .ena(io.ena),
      .strobe(strobe),
      .d(io.ui_in[i]),
      .clean(clean_v[i]),
      .rise(rise_v[i]),
      .fall(fall_v[i])
    );
  end
  assign io.clean = clean_v;
  assign io.rise = rise_v;
  assign io.fall = fall_v;
  assign io.changed = |(rise_v | fall_v);
endmodule

// File: tb/tb_tt_input_debounce.sv
// tb_tt_input_debounce: directed checks of reset, bounce, glitch, enable, prescale and multi-bit edges.
module tb_tt_input_debounce;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int rc, fc, at;
  always #5 clk = ~clk;
  tt_input_debounce_if ifa ();
  tt_input_debounce_if ifb ();
  tt_input_debounce dut_a (.clk(clk), .rst_n(rst_n), .io(ifa));
  tt_input_debounce #(.PRESCALE(3)) dut_b (.clk(clk), .rst_n(rst_n), .io(ifb));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic watch_a(input int n, input int b, output int r, output int f, output int first);
    r = 0;
    f = 0;
    first = -1;
    for (int k = 1; k <= n; k++) begin
      step(1);
      if (ifa.rise[b]) begin
        r++;
        if (first < 0) first = k;
      end
      if (ifa.fall[b]) f++;
    end
  endtask
  initial begin
    ifa.ena = 1'b1;
    ifa.ui_in = 8'hFF;
    ifb.ena = 1'b1;
    ifb.ui_in = 8'h00;
    step(3);
    chk("rst_clean", ifa.clean, 8'h00);
    chk("rst_rise", ifa.rise, 8'h00);
    chk("rst_fall", ifa.fall, 8'h00);
    chk("rst_changed", ifa.changed, 1'b0);
    rst_n = 1'b1;
    step(5);
    chk("rel_early_clean", ifa.clean, 8'h00);
    step(1);
    chk("rel_clean", ifa.clean, 8'hFF);
    chk("rel_rise", ifa.rise, 8'hFF);
    chk("rel_fall", ifa.fall, 8'h00);
    chk("rel_changed", ifa.changed, 1'b1);
    step(1);
    chk("rel_rise_end", ifa.rise, 8'h00);
    chk("rel_changed_end", ifa.changed, 1'b0);
    ifa.ui_in = 8'h00;
    step(8);
    chk("all_low", ifa.clean, 8'h00);
    ifa.ui_in[1] = 1'b1; step(1);
    ifa.ui_in[1] = 1'b0; step(1);
    ifa.ui_in[1] = 1'b1; step(1);
    ifa.ui_in[1] = 1'b0; step(1);
    ifa.ui_in[1] = 1'b1;
    watch_a(10, 1, rc, fc, at);
    chk("bounce_rise_cnt", rc, 1);
    chk("bounce_rise_at", at, 6);
    chk("bounce_fall_cnt", fc, 0);
    chk("bounce_clean", ifa.clean, 8'h02);
    ifa.ui_in[0] = 1'b1;
    watch_a(3, 0, rc, fc, at);
    chk("glitch_rise_a", rc, 0);
    ifa.ui_in[0] = 1'b0;
    watch_a(8, 0, rc, fc, at);
    chk("glitch_rise_b", rc, 0);
    chk("glitch_clean", ifa.clean, 8'h02);
    ifa.ui_in[0] = 1'b1;
    watch_a(8, 0, rc, fc, at);
    chk("hold_rise_cnt", rc, 1);
    chk("hold_rise_at", at, 6);
    ifa.ena = 1'b0;
    ifa.ui_in[3] = 1'b1;
    step(8);
    chk("ena_off_clean", ifa.clean, 8'h03);
    chk("ena_off_rise", ifa.rise, 8'h00);
    ifa.ena = 1'b1;
    step(3);
    chk("ena_on_early", ifa.clean, 8'h03);
    step(1);
    chk("ena_on_clean", ifa.clean, 8'h0B);
    chk("ena_on_rise", ifa.rise, 8'h08);
    ifa.ui_in = 8'h0F;
    step(8);
    chk("sim_pre", ifa.clean, 8'h0F);
    ifa.ui_in = 8'hF0;
    step(5);
    chk("sim_early_clean", ifa.clean, 8'h0F);
    chk("sim_early_changed", ifa.changed, 1'b0);
    step(1);
    chk("sim_clean", ifa.clean, 8'hF0);
    chk("sim_rise", ifa.rise, 8'hF0);
    chk("sim_fall", ifa.fall, 8'h0F);
    chk("sim_changed", ifa.changed, 1'b1);
    step(1);
    chk("sim_changed_end", ifa.changed, 1'b0);
    chk("sim_fall_end", ifa.fall, 8'h00);
    ifa.ui_in = 8'hFF;
    step(3);
    rst_n = 1'b0;
    #1;
    chk("midrst_clean", ifa.clean, 8'h00);
    step(1);
    rst_n = 1'b1;
    step(5);
    chk("midrst_early", ifa.clean, 8'h00);
    step(1);
    chk("midrst_clean_hi", ifa.clean, 8'hFF);
    chk("midrst_rise", ifa.rise, 8'hFF);
    ifb.ui_in[5] = 1'b1;
    rc = 0;
    fc = 0;
    at = -1;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      if (ifb.rise[5]) begin
        rc++;
        if (at < 0) at = k;
      end
      if (ifb.fall != 8'h00) fc++;
    end
    chk("pre_rise_cnt", rc, 1);
    chk("pre_not_early", at >= 12, 1'b1);
    chk("pre_not_late", at <= 14, 1'b1);
    chk("pre_fall_cnt", fc, 0);
    chk("pre_clean", ifb.clean, 8'h20);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
